mac_bringup_ctrl: RTL and testbench
===================================

# mac_bringup_ctrl

Sequences bring-up of the QSFP 25GE link. It holds the GT and MAC in reset, then waits for `rx_gt_locked` and `rx_block_lock`. It requires the block lock to stay stable before asserting `mac_ready`, the green light user logic waits on before sending frames. It retries on timeout or lock loss, gives up after a bounded number of consecutive failures, and sits in the MAC top between the GT/MAC core status outputs and the core reset inputs.

## Interface
- `RESET_CYCLES`, 16: cycles each reset phase is held.
- `GT_LOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_GT.
- `BLOCK_LOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_BLOCK.
- `STABLE_CYCLES`, 256: cycles block lock must stay continuously high before READY.
- `MAX_RETRY`, 7: number of consecutive failures that forces FAIL (≥1).
- `CNT_W`, 24: phase counter width; must hold the largest cycle parameter minus 1.
- `clk`  in  1  125 MHz free-running init clock; the only clock.
- `sys_reset`  in  1  asynchronous, active-high reset.
- `restart`  in  1  one-cycle soft restart request.
- `rx_gt_locked`  in  1  GT lock status; asynchronous to `clk`.
- `rx_block_lock`  in  1  PCS block lock status; asynchronous to `clk`.
- `gt_reset`  out  1  GT reset request, active-high.
- `mac_reset`  out  1  MAC/PCS reset request, active-high.
- `mac_ready`  out  1  link usable.
- `link_down`  out  1  one-cycle pulse when a link leaves READY.
- `fail`  out  1  high in FAIL.
- `retry_count`  out  3  consecutive failure count, saturating at MAX_RETRY.
- `state`  out  3  current state encoding, for debug.

## Operation
- Both lock inputs pass through 2-flop synchronizers (`*_s`), reset to 0. The FSM uses only the synchronized values.
- Phase counter `cnt` clears on every state entry and increments each cycle in the state.
- States and encodings:
  - RESET_GT (0): leaves to WAIT_GT when `cnt==RESET_CYCLES-1`.
  - WAIT_GT (1):
    - `gt_s` high -> RESET_MAC.
    - Otherwise `cnt==GT_LOCK_TIMEOUT-1` -> RETRY.
  - RESET_MAC (2):
    - `gt_s` low -> RETRY.
    - Otherwise `cnt==RESET_CYCLES-1` -> WAIT_BLOCK.
  - WAIT_BLOCK (3):
    - `gt_s` low -> RETRY.
    - Otherwise `blk_s` high -> STABLE.
    - Otherwise timeout at `BLOCK_LOCK_TIMEOUT-1` -> RETRY.
  - STABLE (4):
    - `gt_s` low -> RETRY.
    - Otherwise `blk_s` low -> WAIT_BLOCK. This is not a failure; the WAIT_BLOCK timeout restarts.
    - Otherwise `cnt==STABLE_CYCLES-1` -> READY.
  - READY (5):
    - Entry clears `retry_count`.
    - `gt_s` or `blk_s` low -> RETRY, with `link_down` high for that one transition cycle.
  - RETRY (6): lasts one cycle.
    - `retry_count` increments, saturating.
    - If the new value is `>= MAX_RETRY` -> FAIL, otherwise RESET_GT.
  - FAIL (7): terminal. Leaves only on `restart` or `sys_reset`.
- `restart` has the highest priority, in any state. The next state is RESET_GT and `retry_count` clears to 0.
- Lock input priority: lock success beats a timeout on the same cycle. Loss of `gt_s` beats all other conditions except `restart`.
- Output decode, registered from the next state so outputs change on the same edge as `state`:
  - `gt_reset` = state ∈ {RESET_GT, RETRY, FAIL}.
  - `mac_reset` = state ∈ {RESET_GT, WAIT_GT, RESET_MAC, RETRY, FAIL}.
  - `mac_ready` = READY.
  - `fail` = FAIL.

## Timing
- Reset values:
  - state = RESET_GT, cnt = 0.
  - `gt_reset` = 1, `mac_reset` = 1.
  - `mac_ready` = 0, `link_down` = 0, `fail` = 0, `retry_count` = 0.
  - Synchronizers = 0.
  - All values apply immediately on `sys_reset` assertion, including mid-operation.
- After reset release, `gt_reset` stays high for exactly RESET_CYCLES rising edges.
- Lock input rising to FSM transition: 3 edges, made of 2 synchronizer edges plus 1 FSM edge. Lock loss to `mac_ready` falling: also 3 edges.
- Latencies measured from the `rx_block_lock` rise sampled at edge k:
  - STABLE entered at edge k+2.
  - `mac_ready` rises at edge k+2+STABLE_CYCLES.
- `mac_reset` deasserts RESET_CYCLES edges after RESET_MAC entry.
- `link_down` is high for exactly one cycle per READY exit. It does not pulse on exits from other states.

## Test plan
Bench parameters: RESET_CYCLES=4, GT_LOCK_TIMEOUT=32, BLOCK_LOCK_TIMEOUT=64, STABLE_CYCLES=8, MAX_RETRY=3.

- Nominal: release reset, raise gt lock at cycle 10, then block lock at cycle 40 (sampled edge k).
  - `gt_reset` is high for 4 edges, then `mac_reset` falls.
  - `mac_ready` rises at k+10.
  - `retry_count` = 0 and `fail` = 0.
- GT never locks: expect three 32-cycle WAIT_GT windows, each followed by RETRY. Then:
  - state = 7, `fail` = 1, `retry_count` = 3.
  - `gt_reset` = `mac_reset` = 1, stable for 1000 cycles.
- Block-lock glitch: drop block lock for 1 cycle at STABLE cnt = 5.
  - State returns to 3 and `mac_ready` stays 0.
  - After the lock restores, `mac_ready` rises 10 edges after the re-sampled rise.
  - `retry_count` is unchanged.
- Link loss in READY: drop gt lock.
  - `mac_ready` falls 3 edges later with a single-cycle `link_down`.
  - `gt_reset` reasserts and `retry_count` = 1.
  - Re-locking reaches READY again with `retry_count` = 0.
- Restart and reset:
  - `restart` pulse in FAIL -> state 0, `fail` = 0, `retry_count` = 0 on the next edge.
  - `sys_reset` asserted mid-WAIT_BLOCK -> all outputs take their reset values with no clock edge.
- Simultaneous events:
  - Gt lock sampled on WAIT_GT `cnt==31` -> RESET_MAC, not RETRY.
  - `restart` on the same cycle as READY lock loss -> RESET_GT with `retry_count` = 0.

Source files
------------

// File: rtl/mac_bringup_if.sv
// Status/control bundle between the QSFP 25GE bring-up controller and the GT/MAC core.
// master = controller side, slave = core/user side.
interface mac_bringup_if;
    logic       restart;
    logic       rx_gt_locked;
    logic       rx_block_lock;
    logic       gt_reset;
    logic       mac_reset;
    logic       mac_ready;
    logic       link_down;
    logic       fail;
    logic [2:0] retry_count;
    logic [2:0] state;

    modport master (
        input  restart, rx_gt_locked, rx_block_lock,
        output gt_reset, mac_reset, mac_ready, link_down, fail, retry_count, state
    );

    modport slave (
        output restart, rx_gt_locked, rx_block_lock,
        input  gt_reset, mac_reset, mac_ready, link_down, fail, retry_count, state
    );
endinterface

// File: rtl/mac_bringup_ctrl.sv
// QSFP 25GE link bring-up sequencer: GT reset, GT lock, MAC reset, block lock,
// lock stability, then mac_ready; retries on timeout or lock loss up to MAX_RETRY.
module mac_bringup_ctrl #(
    parameter int RESET_CYCLES       = 16,
    parameter int GT_LOCK_TIMEOUT    = 1048576,
    parameter int BLOCK_LOCK_TIMEOUT = 1048576,
    parameter int STABLE_CYCLES      = 256,
    parameter int MAX_RETRY          = 7,
    parameter int CNT_W              = 24
) (
    input  logic          clk,
    input  logic          sys_reset,
    mac_bringup_if.master bus
);

    typedef enum logic [2:0] {
        ST_RESET_GT   = 3'd0,
        ST_WAIT_GT    = 3'd1,
        ST_RESET_MAC  = 3'd2,
        ST_WAIT_BLOCK = 3'd3,
        ST_STABLE     = 3'd4,
        ST_READY      = 3'd5,
        ST_RETRY      = 3'd6,
        ST_FAIL       = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GT_LAST     = CNT_W'(GT_LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BLK_LAST    = CNT_W'(BLOCK_LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);

    logic gt_meta_q, gt_s_q, blk_meta_q, blk_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d, retry_inc;
    logic             gt_reset_q, gt_reset_d;
    logic             mac_reset_q, mac_reset_d;
    logic             ready_q, ready_d;
    logic             link_down_q, link_down_d;
    logic             fail_q, fail_d;

    // Lock status comes from the GT recovered-clock domain.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            gt_meta_q  <= 1'b0;
            gt_s_q     <= 1'b0;
            blk_meta_q <= 1'b0;
            blk_s_q    <= 1'b0;
        end else begin
            gt_meta_q  <= bus.rx_gt_locked;
            gt_s_q     <= gt_meta_q;
            blk_meta_q <= bus.rx_block_lock;
            blk_s_q    <= blk_meta_q;
        end
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q     <= ST_RESET_GT;
            cnt_q       <= '0;
            retry_q     <= '0;
            gt_reset_q  <= 1'b1;
            mac_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            link_down_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            gt_reset_q  <= gt_reset_d;
            mac_reset_q <= mac_reset_d;
            ready_q     <= ready_d;
            link_down_q <= link_down_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        link_down_d = 1'b0;
        retry_inc   = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 3'd1;

        if (bus.restart) begin
            state_d = ST_RESET_GT;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_GT: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_GT;
                end
                ST_WAIT_GT: begin
                    if (gt_s_q)                state_d = ST_RESET_MAC;
                    else if (cnt_q == GT_LAST) state_d = ST_RETRY;
                end
                ST_RESET_MAC: begin
                    if (!gt_s_q)                state_d = ST_RETRY;
                    else if (cnt_q == RST_LAST) state_d = ST_WAIT_BLOCK;
                end
                ST_WAIT_BLOCK: begin
                    if (!gt_s_q)                state_d = ST_RETRY;
                    else if (blk_s_q)           state_d = ST_STABLE;
                    else if (cnt_q == BLK_LAST) state_d = ST_RETRY;
                end
                ST_STABLE: begin
                    // A block-lock dropout here is a re-acquire, not a failure.
                    if (!gt_s_q)                   state_d = ST_RETRY;
                    else if (!blk_s_q)             state_d = ST_WAIT_BLOCK;
                    else if (cnt_q == STABLE_LAST) state_d = ST_READY;
                end
                ST_READY: begin
                    if (!gt_s_q || !blk_s_q) state_d = ST_RETRY;
                end
                ST_RETRY: begin
                    retry_d = retry_inc;
                    state_d = (retry_inc >= RETRY_MAX) ? ST_FAIL : ST_RESET_GT;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
            endcase
        end

        if (state_d == ST_READY && state_q != ST_READY) retry_d = '0;
        if (state_q == ST_READY && state_d != ST_READY) link_down_d = 1'b1;

        cnt_d = (bus.restart || state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they move with state_q.
        gt_reset_d  = state_d inside {ST_RESET_GT, ST_RETRY, ST_FAIL};
        mac_reset_d = state_d inside {ST_RESET_GT, ST_WAIT_GT, ST_RESET_MAC, ST_RETRY, ST_FAIL};
        ready_d     = (state_d == ST_READY);
        fail_d      = (state_d == ST_FAIL);
    end

    assign bus.gt_reset    = gt_reset_q;
    assign bus.mac_reset   = mac_reset_q;
    assign bus.mac_ready   = ready_q;
    assign bus.link_down   = link_down_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mac_bringup_ctrl.sv
// Directed bring-up scenarios with randomized lock arrival times; expected edge
// numbers are computed from the lock-sample edge and the cycle parameters.
module tb_mac_bringup_ctrl;

    localparam int RC  = 4;
    localparam int GTO = 32;
    localparam int BTO = 64;
    localparam int SC  = 8;
    localparam int MR  = 3;

    localparam int W_STATE = 0;
    localparam int W_READY = 1;
    localparam int W_MRST  = 2;

    logic clk = 1'b0;
    logic sys_reset = 1'b0;
    int   edge_n = 0;
    int   errors = 0;
    int   checks = 0;

    mac_bringup_if bus();

    mac_bringup_ctrl #(
        .RESET_CYCLES(RC), .GT_LOCK_TIMEOUT(GTO), .BLOCK_LOCK_TIMEOUT(BTO),
        .STABLE_CYCLES(SC), .MAX_RETRY(MR), .CNT_W(24)
    ) dut (
        .clk(clk),
        .sys_reset(sys_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sel(input int which);
        case (which)
            W_STATE: return int'(bus.state);
            W_READY: return int'(bus.mac_ready);
            W_MRST:  return int'(bus.mac_reset);
            default: return int'(bus.retry_count);
        endcase
    endfunction

    // Returns the edge at which the watched output first equals val, or -1.
    task automatic wait_for(input int which, input int val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (sel(which) == val) begin
                at = edge_n;
                break;
            end
            tick();
        end
    endtask

    // Starts on the edge at which reset was released; inputs are low.
    task automatic bringup();
        int d, k, e, e2;
        repeat (RC - 1) tick();
        chk("gt_reset_hold", int'(bus.gt_reset), 1);
        tick();
        chk("gt_reset_fall", int'(bus.gt_reset), 0);
        chk("wait_gt_entry", int'(bus.state), 1);
        d = $urandom_range(0, 20);
        repeat (d) tick();
        bus.rx_gt_locked = 1'b1;
        k = edge_n + 1;
        wait_for(W_STATE, 2, 200, e);
        chk("reset_mac_entry", e, k + 2);
        wait_for(W_MRST, 0, 200, e2);
        chk("mac_reset_fall", e2, e + RC);
        chk("wait_block_entry", int'(bus.state), 3);
        d = $urandom_range(0, 30);
        repeat (d) tick();
        bus.rx_block_lock = 1'b1;
        k = edge_n + 1;
        wait_for(W_STATE, 4, 200, e);
        chk("stable_entry", e, k + 2);
        wait_for(W_READY, 1, 200, e);
        chk("ready_latency", e, k + 2 + SC);
        chk("ready_retry", int'(bus.retry_count), 0);
        chk("ready_fail", int'(bus.fail), 0);
        chk("ready_mac_reset", int'(bus.mac_reset), 0);
    endtask

    initial begin
        int e, s, w, rr, f, bad;
        bus.restart       = 1'b0;
        bus.rx_gt_locked  = 1'b0;
        bus.rx_block_lock = 1'b0;

        #1 sys_reset = 1'b1;
        #1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_gt_reset", int'(bus.gt_reset), 1);
        chk("rst_mac_reset", int'(bus.mac_reset), 1);
        chk("rst_ready", int'(bus.mac_ready), 0);
        chk("rst_fail", int'(bus.fail), 0);
        chk("rst_retry", int'(bus.retry_count), 0);
        repeat (3) tick();
        sys_reset = 1'b0;
        bringup();

        // Link loss in READY.
        repeat ($urandom_range(1, 10)) tick();
        bus.rx_gt_locked = 1'b0;
        s = edge_n;
        wait_for(W_READY, 0, 50, e);
        chk("loss_ready_fall", e, s + 3);
        chk("loss_link_down", int'(bus.link_down), 1);
        chk("loss_gt_reset", int'(bus.gt_reset), 1);
        chk("loss_state", int'(bus.state), 6);
        tick();
        chk("loss_link_down_width", int'(bus.link_down), 0);
        chk("loss_retry", int'(bus.retry_count), 1);
        chk("loss_reset_gt", int'(bus.state), 0);

        // Relock with a one-cycle block-lock glitch in STABLE.
        wait_for(W_STATE, 1, 50, e);
        repeat ($urandom_range(0, 20)) tick();
        bus.rx_gt_locked = 1'b1;
        wait_for(W_STATE, 4, 200, s);
        repeat (3) tick();
        bus.rx_block_lock = 1'b0;
        tick();
        bus.rx_block_lock = 1'b1;
        tick();
        chk("glitch_still_stable", int'(bus.state), 4);
        tick();
        chk("glitch_wait_block", int'(bus.state), 3);
        chk("glitch_no_ready", int'(bus.mac_ready), 0);
        chk("glitch_retry_kept", int'(bus.retry_count), 1);
        wait_for(W_READY, 1, 200, e);
        chk("glitch_ready_latency", e, (s + 5) + 2 + SC);
        chk("relock_retry_clear", int'(bus.retry_count), 0);

        // Restart on the same edge as a READY lock loss.
        repeat ($urandom_range(1, 10)) tick();
        bus.rx_block_lock = 1'b0;
        repeat (2) tick();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        chk("rst_loss_state", int'(bus.state), 0);
        chk("rst_loss_retry", int'(bus.retry_count), 0);
        chk("rst_loss_ready", int'(bus.mac_ready), 0);
        tick();
        bus.rx_gt_locked = 1'b0;
        chk("rst_loss_state_next", int'(bus.state), 0);
        chk("rst_loss_retry_next", int'(bus.retry_count), 0);

        // GT never locks: MR timeout windows, then FAIL.
        rr = -1;
        for (int i = 0; i < MR; i++) begin
            wait_for(W_STATE, 1, 100, w);
            wait_for(W_STATE, 6, 100, rr);
            chk("gt_timeout_window", rr - w, GTO);
        end
        wait_for(W_STATE, 7, 50, f);
        chk("fail_entry", f, rr + 1);
        chk("fail_flag", int'(bus.fail), 1);
        chk("fail_retry", int'(bus.retry_count), MR);
        chk("fail_gt_reset", int'(bus.gt_reset), 1);
        chk("fail_mac_reset", int'(bus.mac_reset), 1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!(bus.state == 3'd7 && bus.fail && bus.gt_reset && bus.mac_reset &&
                  bus.retry_count == 3'(MR) && !bus.mac_ready)) bad++;
        end
        chk("fail_hold", bad, 0);

        // Restart out of FAIL.
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        s = edge_n;
        chk("restart_state", int'(bus.state), 0);
        chk("restart_fail", int'(bus.fail), 0);
        chk("restart_retry", int'(bus.retry_count), 0);

        // GT lock seen exactly on the last WAIT_GT cycle.
        wait_for(W_STATE, 1, 50, w);
        chk("restart_wait_gt", w, s + RC);
        repeat (GTO - 3) tick();
        bus.rx_gt_locked = 1'b1;
        repeat (2) tick();
        chk("edge_timeout_pending", int'(bus.state), 1);
        tick();
        chk("edge_lock_wins", int'(bus.state), 2);

        // Async reset mid-WAIT_BLOCK.
        wait_for(W_STATE, 3, 50, e);
        repeat (2) tick();
        #2;
        sys_reset = 1'b1;
        bus.rx_gt_locked  = 1'b0;
        bus.rx_block_lock = 1'b0;
        #1;
        chk("async_state", int'(bus.state), 0);
        chk("async_gt_reset", int'(bus.gt_reset), 1);
        chk("async_mac_reset", int'(bus.mac_reset), 1);
        chk("async_ready", int'(bus.mac_ready), 0);
        chk("async_link_down", int'(bus.link_down), 0);
        chk("async_fail", int'(bus.fail), 0);

        // Further bring-ups with fresh random lock timing.
        for (int it = 0; it < 3; it++) begin
            tick();
            sys_reset = 1'b0;
            bringup();
            sys_reset = 1'b1;
            bus.rx_gt_locked  = 1'b0;
            bus.rx_block_lock = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
